image_streamer: RTL and testbench
=================================

Name: image_streamer

Overview:
- Transmit-side counterpart of the 3x3 window generator.
- Holds one IMG_W x IMG_H frame in an internal buffer loaded by a host write port. On a start pulse it replays the frame as a raster pixel stream: row 0 first, left to right.
- Drives pixel data plus a one-per-pixel valid strobe, which connects directly to the window generator's pixel/enable inputs. Adds frame markers (sof/eol/eof), a busy level and a done pulse for the controlling FSM.

Parameters:
- IMG_W, 5, pixels per row (>=3).
- IMG_H, 5, rows per frame (>=3).
- PIX_W, 8, pixel width in bits.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- wr_en  in  1  buffer write strobe.
- wr_addr  in  AW  buffer write address, raster order; AW = $clog2(IMG_W*IMG_H).
- wr_data  in  PIX_W  pixel to store.
- start  in  1  begin streaming one frame.
- stall  in  1  hold the stream; no pixel is emitted this cycle.
- pixel_out  out  PIX_W  streamed pixel.
- pix_valid  out  1  pixel_out valid this cycle; drives the window generator's en.
- sof  out  1  with pix_valid, marks pixel (0,0).
- eol  out  1  with pix_valid, marks the last column of a row.
- eof  out  1  with pix_valid, marks the last pixel of the frame.
- busy  out  1  high while streaming.
- done  out  1  one-cycle pulse after the eof pixel.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; read pointer, column counter and row counter = 0.
  - pixel_out, pix_valid, sof, eol, eof, busy, done all = 0.
  - Buffer contents are not cleared.
- Buffer:
  - N = IMG_W*IMG_H entries.
  - Write is synchronous on wr_en and is accepted only when state != STREAM.
  - Writes with wr_addr >= N are ignored.
  - Read is asynchronous at the read pointer; all outputs are registered.
- FSM states: IDLE, STREAM, DONE.
  - IDLE: start=1 -> STREAM; pointer and counters cleared.
  - STREAM, on each clock:
    - stall=0: pixel_out<=buf[ptr]; pix_valid<=1; sof<=(ptr==0); eol<=(col==IMG_W-1); eof<=(ptr==N-1); ptr, col and row advance. col wraps to 0 at IMG_W-1, and row increments on that wrap.
    - stall=1: pix_valid, sof, eol and eof <=0; pixel_out, ptr and counters hold.
    - When the non-stalled cycle with ptr==N-1 is taken, go to DONE.
  - DONE: lasts exactly one cycle with done=1; all strobes 0.
    - start=1 in DONE -> STREAM (back-to-back frames).
    - Otherwise -> IDLE.
- busy is 1 exactly while state==STREAM.
- Latency: start sampled at edge k -> busy=1 after edge k. With stall=0, pixel 0 is valid after edge k+1.
  - Unstalled frame: N consecutive valid cycles, then done on the next cycle.
- start while in STREAM is ignored; the frame in progress is not restarted.
- A stall asserted in IDLE or DONE has no effect.
- Reset mid-stream aborts immediately; no done pulse is produced. The next start replays from pixel 0.
- A frame always emits exactly N valid pixels, however many stall cycles occur.

Decomposition:
- Shared CNN package holds:
  - PIX_W default;
  - the address-width helper (clog2 of IMG_W*IMG_H);
  - the FSM state encoding (IDLE=0, STREAM=1, DONE=2).
- One sub-module, image_buffer_ram: N x PIX_W, synchronous write, async read. It is reusable later for output feature-map capture.
- Counters and FSM stay in image_streamer.

Test Plan (IMG_W=IMG_H=5):
- Load ramp data[i]=i for i=0..24; pulse start with stall=0 -> 25 consecutive pix_valid cycles with pixel_out 0..24.
  - sof on pixel 0 only; eol on pixels 4,9,14,19,24; eof on pixel 24 only.
  - done one cycle later; busy high from the cycle after start to the eof cycle inclusive.
- Same frame with stall high on alternate cycles and for a 6-cycle burst mid-row -> still exactly 25 valid pixels, values 0..24 in order.
  - Markers stay aligned; no valid pixel appears during stall.
- During streaming, pulse start at pixel 10 and write wr_addr=20, wr_data=0xAA -> stream is unaffected.
  - Pixel 20 reads 20; a second frame after done still reads 20 at index 20.
- Assert rst=0 at pixel 12 -> all outputs 0 in the same cycle, no done pulse.
  - After release, start replays from pixel 0 with value 0.
- Pulse start in the DONE cycle -> second frame begins with no IDLE cycle; 50 total valid pixels.
  - done pulses exactly twice.
- Write wr_addr=25 (out of range) with 0xFF, then stream -> all 25 pixels match the loaded ramp.

Source files
------------

// File: rtl/image_streamer_pkg.sv
// Shared types and helpers for the CNN image path.
// Holds the default pixel width, the buffer address-width helper and the streamer FSM encoding.
package image_streamer_pkg;

   localparam int PIX_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DONE   = 2'd2
   } state_t;

   // Address width for a w x h frame buffer held in raster order.
   function automatic int addr_w(input int w, input int h);
      return (w * h > 1) ? $clog2(w * h) : 1;
   endfunction

endpackage

// File: rtl/image_buffer_ram.sv
// DEPTH x WIDTH frame buffer: synchronous write, asynchronous read.
// Ports: clk, we/waddr/wdata write port (out-of-range addresses ignored), raddr/rdata read port.
module image_buffer_ram #(
   parameter int DEPTH = 25,
   parameter int WIDTH = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Contents are deliberately not reset; a frame survives a reset.
   always_ff @(posedge clk) begin
      if (we && ({1'b0, waddr} < (AW+1)'(DEPTH)))
         mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/image_streamer.sv
// Replays a buffered IMG_W x IMG_H frame as a raster pixel stream with frame markers.
// Ports: clk, rst (async, active-low), wr_en/wr_addr/wr_data host write, start, stall;
// pixel_out, pix_valid, sof, eol, eof, busy, done (all registered).
module image_streamer
   import image_streamer_pkg::*;
#(
   parameter int IMG_W = 5,
   parameter int IMG_H = 5,
   parameter int PIX_W = PIX_W_DEF,
   localparam int N    = IMG_W * IMG_H,
   localparam int AW   = addr_w(IMG_W, IMG_H)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [PIX_W-1:0] wr_data,
   input  logic             start,
   input  logic             stall,
   output logic [PIX_W-1:0] pixel_out,
   output logic             pix_valid,
   output logic             sof,
   output logic             eol,
   output logic             eof,
   output logic             busy,
   output logic             done
);

   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);

   state_t           state;
   logic [AW-1:0]    ptr;
   logic [CW-1:0]    col;
   logic [RW-1:0]    row;
   logic [PIX_W-1:0] rd_data;
   logic             last_pix;
   logic             last_col;

   assign last_pix = (ptr == AW'(N - 1));
   assign last_col = (col == CW'(IMG_W - 1));

   // The host may not overwrite the frame while it is being replayed.
   image_buffer_ram #(
      .DEPTH (N),
      .WIDTH (PIX_W),
      .AW    (AW)
   ) u_buf (
      .clk   (clk),
      .we    (wr_en && (state != STREAM)),
      .waddr (wr_addr),
      .wdata (wr_data),
      .raddr (ptr),
      .rdata (rd_data)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         ptr       <= '0;
         col       <= '0;
         row       <= '0;
         pixel_out <= '0;
         pix_valid <= 1'b0;
         sof       <= 1'b0;
         eol       <= 1'b0;
         eof       <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         pix_valid <= 1'b0;
         sof       <= 1'b0;
         eol       <= 1'b0;
         eof       <= 1'b0;
         done      <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state <= STREAM;
                  busy  <= 1'b1;
                  ptr   <= '0;
                  col   <= '0;
                  row   <= '0;
               end
            end
            STREAM: begin
               if (!stall) begin
                  pixel_out <= rd_data;
                  pix_valid <= 1'b1;
                  sof       <= (ptr == '0);
                  eol       <= last_col;
                  eof       <= last_pix;
                  if (last_pix) begin
                     // Counters park at zero so a back-to-back frame starts clean.
                     state <= DONE;
                     ptr   <= '0;
                     col   <= '0;
                     row   <= '0;
                  end else begin
                     ptr <= ptr + 1'b1;
                     if (last_col) begin
                        col <= '0;
                        row <= row + 1'b1;
                     end else begin
                        col <= col + 1'b1;
                     end
                  end
               end
            end
            DONE: begin
               // busy covers the eof cycle; it drops with the done pulse
               // unless the next frame is already requested.
               done <= 1'b1;
               if (start) begin
                  state <= STREAM;
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_image_streamer.sv
// Directed/randomized bench for image_streamer (5x5 frame, 8-bit pixels).
// Reference model: frame array plus per-pixel marker rules from raster index.
module tb_image_streamer;

   localparam int W  = 5;
   localparam int H  = 5;
   localparam int N  = W * H;
   localparam int PW = 8;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          wr_en = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [PW-1:0] wr_data = '0;
   logic          start = 1'b0;
   logic          stall = 1'b0;
   logic [PW-1:0] pixel_out;
   logic          pix_valid;
   logic          sof;
   logic          eol;
   logic          eof;
   logic          busy;
   logic          done;

   int checks = 0;
   int errors = 0;
   int valid_cnt = 0;
   int done_cnt = 0;
   logic [PW-1:0] model [N];

   image_streamer #(
      .IMG_W (W),
      .IMG_H (H),
      .PIX_W (PW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .start     (start),
      .stall     (stall),
      .pixel_out (pixel_out),
      .pix_valid (pix_valid),
      .sof       (sof),
      .eol       (eol),
      .eof       (eof),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_pix"}, 32'(pixel_out), 0);
      chk({tag, "_strobes"}, {sof, eol, eof, pix_valid}, 0);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_done"}, 32'(done), 0);
   endtask

   task automatic load(input bit ramp);
      for (int i = 0; i < N; i++) begin
         wr_en   = 1'b1;
         wr_addr = AW'(i);
         wr_data = ramp ? PW'(i) : PW'($urandom);
         model[i] = wr_data;
         @(negedge clk);
      end
      wr_en = 1'b0;
   endtask

   task automatic kick();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_start", 32'(busy), 1);
      chk("idle_after_start", 32'(pix_valid), 0);
   endtask

   // mode 0: no stall, 1: alternate, 2: 6-cycle burst mid-row, 3: random
   task automatic body(input int mode, input int abort_at, input bit poke);
      int idx = 0;
      int cyc = 0;
      int burst = 0;
      bit burst_used = 1'b0;
      bit poked = 1'b0;
      bit st;
      while (idx < N) begin
         if (cyc >= 400) begin
            chk("frame_timeout", 32'(idx), N);
            stall = 1'b0;
            return;
         end
         st = 1'b0;
         case (mode)
            1: st = cyc[0];
            2: begin
               if (idx == 7 && !burst_used) begin
                  burst = 6;
                  burst_used = 1'b1;
               end
               st = (burst > 0);
               if (burst > 0) burst--;
            end
            3: st = ($urandom_range(0, 2) == 0);
            default: st = 1'b0;
         endcase
         stall = st;
         if (poke && idx == 10 && !poked) begin
            start   = 1'b1;
            wr_en   = 1'b1;
            wr_addr = AW'(20);
            wr_data = 8'hAA;
            poked   = 1'b1;
         end
         @(negedge clk);
         cyc++;
         start = 1'b0;
         wr_en = 1'b0;
         chk("busy_in_frame", 32'(busy), 1);
         chk("no_done_in_frame", 32'(done), 0);
         if (st) begin
            chk("stall_valid", 32'(pix_valid), 0);
            chk("stall_marks", {sof, eol, eof}, 0);
         end else begin
            chk($sformatf("valid_%0d", idx), 32'(pix_valid), 1);
            chk($sformatf("pixel_%0d", idx), 32'(pixel_out), 32'(model[idx]));
            chk($sformatf("sof_%0d", idx), 32'(sof), 32'(idx == 0));
            chk($sformatf("eol_%0d", idx), 32'(eol), 32'(idx % W == W - 1));
            chk($sformatf("eof_%0d", idx), 32'(eof), 32'(idx == N - 1));
            valid_cnt++;
            idx++;
            if (idx == abort_at) begin
               stall = 1'b0;
               return;
            end
         end
      end
      stall = 1'b0;
   endtask

   task automatic end_frame();
      @(negedge clk);
      chk("done_pulse", 32'(done), 1);
      chk("busy_at_done", 32'(busy), 0);
      chk("valid_at_done", {pix_valid, sof, eol, eof}, 0);
      if (done) done_cnt++;
      @(negedge clk);
      chk("done_single", 32'(done), 0);
      chk("busy_idle", 32'(busy), 0);
   endtask

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      rst = 1'b1;
      @(negedge clk);

      // Stall in IDLE has no effect
      stall = 1'b1;
      @(negedge clk);
      chk("idle_stall_busy", 32'(busy), 0);
      chk("idle_stall_valid", 32'(pix_valid), 0);
      stall = 1'b0;

      // Plain ramp frame
      load(1'b1);
      kick();
      body(0, -1, 1'b0);
      end_frame();

      // Alternate stalls, then a mid-row burst
      kick();
      body(1, -1, 1'b0);
      end_frame();
      kick();
      body(2, -1, 1'b0);
      end_frame();

      // start and write during streaming are ignored
      kick();
      body(0, -1, 1'b1);
      end_frame();
      kick();
      body(0, -1, 1'b0);
      end_frame();

      // Reset mid-frame after pixel 12
      kick();
      body(0, 13, 1'b0);
      #2 rst = 1'b0;
      #1 chk_all_zero("abort");
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("abort_no_done", 32'(done), 0);
         chk("abort_no_valid", 32'(pix_valid), 0);
      end
      kick();
      body(0, -1, 1'b0);
      end_frame();

      // Back-to-back frames
      valid_cnt = 0;
      done_cnt = 0;
      kick();
      body(0, -1, 1'b0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("b2b_done", 32'(done), 1);
      chk("b2b_busy", 32'(busy), 1);
      chk("b2b_gap_valid", 32'(pix_valid), 0);
      if (done) done_cnt++;
      body(3, -1, 1'b0);
      end_frame();
      chk("b2b_valid_count", 32'(valid_cnt), 50);
      chk("b2b_done_count", 32'(done_cnt), 2);

      // Out-of-range writes leave the frame intact
      load(1'b1);
      for (int a = N; a < 32; a++) begin
         wr_en   = 1'b1;
         wr_addr = AW'(a);
         wr_data = 8'hFF;
         @(negedge clk);
      end
      wr_en = 1'b0;
      kick();
      body(3, -1, 1'b0);
      end_frame();

      // Random data, random stalls
      for (int f = 0; f < 3; f++) begin
         load(1'b0);
         kick();
         body(3, -1, 1'b0);
         end_frame();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
